// File: rtl/uart_mem_bridge_pkg.sv
// Shared definitions for the UART memory bridge.
//   br_state_t      : bridge FSM states
//   *_LEN_*         : packet lengths (bytes sent / bytes expected back)
//   DEFAULT_ACK_BYTE: byte the host returns to acknowledge a store
//   pkt_byte()      : selects byte N of the outgoing request packet
package uart_mem_bridge_pkg;

  typedef enum logic [1:0] {
    BR_IDLE = 2'd0,
    BR_SEND = 2'd1,
    BR_RECV = 2'd2,
    BR_DONE = 2'd3
  } br_state_t;

  localparam logic [3:0] SEND_LEN_LOAD  = 4'd5;
  localparam logic [3:0] SEND_LEN_STORE = 4'd9;
  localparam logic [3:0] RECV_LEN_LOAD  = 4'd4;
  localparam logic [3:0] RECV_LEN_STORE = 4'd1;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;

  // Packet layout: header, address LSB first, then store data LSB first.
  function automatic logic [7:0] pkt_byte(input logic [3:0]  idx,
                                          input logic        we,
                                          input logic [3:0]  mask,
                                          input logic [31:0] addr,
                                          input logic [31:0] wdata);
    logic [7:0] b;
    case (idx)
      4'd0:    b = {mask, 3'b000, we};
      4'd1:    b = addr[7:0];
      4'd2:    b = addr[15:8];
      4'd3:    b = addr[23:16];
      4'd4:    b = addr[31:24];
      4'd5:    b = wdata[7:0];
      4'd6:    b = wdata[15:8];
      4'd7:    b = wdata[23:16];
      4'd8:    b = wdata[31:24];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/uart_mem_bridge.sv
// uart_mem_bridge: serialises one CPU load/store request into a byte packet
// for uart_trans, then deserialises the host reply into a one-cycle response.
// Ports:
//   CLK, RST                      clock, asynchronous active-high reset
//   req_valid/req_ready           request handshake (ready only when idle)
//   req_we/req_mask/req_addr/req_wdata  request fields, registered on accept
//   resp_valid/resp_err/resp_rdata      one-cycle completion, error flag, load data
//   send_flag/send_data/sendable  push side of the uart_trans send FIFO
//   recv_flag/recv_data/receivable pop side of the uart_trans receive FIFO
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int unsigned TIMEOUT  = 1000000,
  parameter logic [7:0]  ACK_BYTE = DEFAULT_ACK_BYTE
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_mask,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic        send_flag,
  output logic [7:0]  send_data,
  input  logic        sendable,
  output logic        recv_flag,
  input  logic [7:0]  recv_data,
  input  logic        receivable
);

  br_state_t   state, state_next;

  logic        we_r;
  logic [3:0]  mask_r;
  logic [31:0] addr_r;
  logic [31:0] wdata_r;

  logic [3:0]  idx;
  logic [3:0]  idx_inc;
  logic        gap;          // idle cycle after each push/pop so FIFO flags settle
  logic [31:0] tcnt;
  logic        bad_ack;
  logic        accept;
  logic        timeout_hit;
  logic [3:0]  send_len;
  logic [3:0]  recv_len;

  assign send_len = we_r ? SEND_LEN_STORE : SEND_LEN_LOAD;
  assign recv_len = we_r ? RECV_LEN_STORE : RECV_LEN_LOAD;
  assign idx_inc  = idx + 4'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= BR_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    timeout_hit = 1'b0;
    send_flag   = 1'b0;
    recv_flag   = 1'b0;
    req_ready   = (state == BR_IDLE);
    resp_valid  = (state == BR_DONE);
    case (state)
      BR_IDLE: begin
        if (req_valid) begin
          accept     = 1'b1;
          state_next = BR_SEND;
        end
      end
      BR_SEND: begin
        if (!gap && idx != send_len && sendable) send_flag = 1'b1;
        else if (gap && idx == send_len)         state_next = BR_RECV;
      end
      BR_RECV: begin
        if (!gap && idx != recv_len && receivable) begin
          recv_flag = 1'b1;
        end else if (gap && idx == recv_len) begin
          state_next = BR_DONE;
        end else if (TIMEOUT != 0 && tcnt >= TIMEOUT - 1) begin
          timeout_hit = 1'b1;
          state_next  = BR_DONE;
        end
      end
      BR_DONE: state_next = BR_IDLE;
      default: state_next = BR_IDLE;
    endcase
  end

  // Request fields are pure data: captured on accept, never reset.
  always_ff @(posedge CLK) begin
    if (accept) begin
      we_r    <= req_we;
      mask_r  <= req_mask;
      addr_r  <= req_addr;
      wdata_r <= req_wdata;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      idx        <= 4'd0;
      gap        <= 1'b0;
      tcnt       <= 32'd0;
      bad_ack    <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 32'd0;
      send_data  <= 8'd0;
    end else begin
      case (state)
        BR_IDLE: begin
          if (accept) begin
            idx       <= 4'd0;
            gap       <= 1'b0;
            tcnt      <= 32'd0;
            bad_ack   <= 1'b0;
            resp_err  <= 1'b0;
            // Header is presented straight from the request port so it is
            // ready on the first SEND cycle.
            send_data <= {req_mask, 3'b000, req_we};
          end
        end
        BR_SEND: begin
          if (send_flag) begin
            idx       <= idx_inc;
            gap       <= 1'b1;
            send_data <= pkt_byte(idx_inc, we_r, mask_r, addr_r, wdata_r);
          end else begin
            gap <= 1'b0;
            if (state_next == BR_RECV) begin
              idx  <= 4'd0;
              tcnt <= 32'd0;
            end
          end
        end
        BR_RECV: begin
          if (recv_flag) begin
            if (we_r) bad_ack <= (recv_data != ACK_BYTE);
            else      resp_rdata[{idx[1:0], 3'b000} +: 8] <= recv_data;
            idx  <= idx_inc;
            gap  <= 1'b1;
            // Reload to 1: the pop cycle itself counts toward the next wait.
            tcnt <= 32'd1;
          end else begin
            gap <= 1'b0;
            if (state_next == BR_DONE) begin
              idx      <= 4'd0;
              resp_err <= bad_ack | timeout_hit;
            end else begin
              tcnt <= tcnt + 32'd1;
            end
          end
        end
        BR_DONE: begin
          idx <= 4'd0;
          gap <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_bridge.sv
module tb_uart_mem_bridge;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_mask;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic        send_flag;
  logic [7:0]  send_data;
  logic        sendable;
  logic        recv_flag;
  logic [7:0]  recv_data;
  logic        receivable;

  uart_mem_bridge #(.TIMEOUT(100), .ACK_BYTE(8'hA5)) dut (
    .CLK(clk), .RST(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_mask(req_mask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .send_flag(send_flag), .send_data(send_data), .sendable(sendable),
    .recv_flag(recv_flag), .recv_data(recv_data), .receivable(receivable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] sent_q[$];
  logic [7:0] recv_q[$];
  logic       hold;
  int         cyc;
  int         last_pop;
  int         push_bad;
  int         pop_bad;

  logic        s_send, s_recv, s_rv, s_err, s_rdy;
  logic [7:0]  s_sdata;
  logic [31:0] s_rdata;

  logic        res_acc, res_done, res_err;
  logic [31:0] res_rdata;
  int          res_cyc;
  int          stall_cnt;

  task automatic update_if();
    receivable = (recv_q.size() != 0);
    recv_data  = receivable ? recv_q[0] : 8'h00;
    sendable   = !hold && (sent_q.size() < 16);
  endtask

  // One clock: sample on the falling edge, apply FIFO effects after the rising edge.
  task automatic tick();
    @(negedge clk);
    s_send  = send_flag;  s_sdata = send_data;
    s_recv  = recv_flag;  s_rv    = resp_valid;
    s_err   = resp_err;   s_rdata = resp_rdata;
    s_rdy   = req_ready;
    if (send_flag && !sendable) push_bad++;
    if (recv_flag && !receivable) pop_bad++;
    @(posedge clk);
    #1;
    cyc++;
    if (s_send) sent_q.push_back(s_sdata);
    if (s_recv && recv_q.size() > 0) begin
      recv_q.delete(0);
      last_pop = cyc;
    end
    update_if();
  endtask

  task automatic do_txn(input logic we, input logic [3:0] mask,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] reply_w, input int n_reply,
                        input int stall_after, input int send_len);
    logic stalled;
    sent_q.delete();
    res_acc = 1'b0; res_done = 1'b0; res_err = 1'bx; res_rdata = 'x;
    req_we = we; req_mask = mask; req_addr = addr; req_wdata = wdata;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !res_acc; i++) begin
      tick();
      if (s_rdy) res_acc = 1'b1;
    end
    req_valid = 1'b0; req_addr = 32'hFFFF_FFFF; req_wdata = 32'h0;
    req_mask = 4'h0;  req_we = ~we;
    stalled = 1'b0;
    for (int i = 0; i < 400 && sent_q.size() < send_len; i++) begin
      if (stall_after != 0 && !stalled && sent_q.size() == stall_after) begin
        hold = 1'b1; update_if();
        repeat (50) tick();
        stall_cnt = sent_q.size();
        hold = 1'b0; update_if();
        stalled = 1'b1;
      end
      tick();
    end
    for (int i = 0; i < n_reply; i++) recv_q.push_back(reply_w[8*i +: 8]);
    update_if();
    for (int i = 0; i < 400 && !res_done; i++) begin
      tick();
      if (s_rv) begin
        res_done = 1'b1; res_err = s_err; res_rdata = s_rdata; res_cyc = cyc;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_total++; if (s_rdy !== 1'b1) $display("FAIL rst_ready: got %b want 1", s_rdy); else n_pass++;
    n_total++; if (s_rv !== 1'b0) $display("FAIL rst_resp_valid: got %b want 0", s_rv); else n_pass++;
    n_total++; if (s_err !== 1'b0) $display("FAIL rst_resp_err: got %b want 0", s_err); else n_pass++;
    n_total++; if (s_rdata !== 32'h0) $display("FAIL rst_rdata: got %h want 0", s_rdata); else n_pass++;
    n_total++; if (s_send !== 1'b0) $display("FAIL rst_send_flag: got %b want 0", s_send); else n_pass++;
    n_total++; if (s_sdata !== 8'h0) $display("FAIL rst_send_data: got %h want 0", s_sdata); else n_pass++;
    n_total++; if (s_recv !== 1'b0) $display("FAIL rst_recv_flag: got %b want 0", s_recv); else n_pass++;
    rst = 1'b0;
    tick();
  endtask

  task automatic test_load();
    logic [7:0] exp_b [5];
    logic [7:0] got;
    exp_b = '{8'h00, 8'h04, 8'h10, 8'h00, 8'h00};
    do_txn(1'b0, 4'h0, 32'h0000_1004, 32'h0, 32'h1234_5678, 4, 0, 5);
    n_total++; if (res_done !== 1'b1) $display("FAIL load_done: got %b want 1", res_done); else n_pass++;
    n_total++; if (sent_q.size() != 5) $display("FAIL load_count: got %0d want 5", sent_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      n_total++; if (got !== exp_b[i]) $display("FAIL load_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_total++; if (res_rdata !== 32'h1234_5678) $display("FAIL load_rdata: got %h want 12345678", res_rdata); else n_pass++;
    n_total++; if (res_err !== 1'b0) $display("FAIL load_err: got %b want 0", res_err); else n_pass++;
    tick();
    n_total++; if (s_rv !== 1'b0) $display("FAIL load_pulse_width: got %b want 0", s_rv); else n_pass++;
  endtask

  task automatic test_store();
    logic [7:0] exp_b [9];
    logic [7:0] got;
    exp_b = '{8'hF1, 8'h10, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    do_txn(1'b1, 4'hF, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0000_00A5, 1, 0, 9);
    n_total++; if (res_done !== 1'b1) $display("FAIL store_done: got %b want 1", res_done); else n_pass++;
    n_total++; if (sent_q.size() != 9) $display("FAIL store_count: got %0d want 9", sent_q.size()); else n_pass++;
    for (int i = 0; i < 9; i++) begin
      got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      n_total++; if (got !== exp_b[i]) $display("FAIL store_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_total++; if (res_err !== 1'b0) $display("FAIL store_err: got %b want 0", res_err); else n_pass++;
    n_total++; if (res_rdata !== 32'h1234_5678) $display("FAIL store_rdata_kept: got %h want 12345678", res_rdata); else n_pass++;
    tick();
  endtask

  task automatic test_store_bad_ack();
    logic [7:0] exp_b [9];
    logic [7:0] got;
    exp_b = '{8'h31, 8'h00, 8'h02, 8'h00, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01};
    do_txn(1'b1, 4'h3, 32'h0000_0200, 32'h0102_0304, 32'h0000_0000, 1, 0, 9);
    for (int i = 0; i < 9; i++) begin
      got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      n_total++; if (got !== exp_b[i]) $display("FAIL badack_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_total++; if (res_done !== 1'b1) $display("FAIL badack_done: got %b want 1", res_done); else n_pass++;
    n_total++; if (res_err !== 1'b1) $display("FAIL badack_err: got %b want 1", res_err); else n_pass++;
    n_total++; if (res_rdata !== 32'h1234_5678) $display("FAIL badack_rdata_kept: got %h want 12345678", res_rdata); else n_pass++;
    tick();
    n_total++; if (s_rdy !== 1'b1) $display("FAIL badack_ready_next: got %b want 1", s_rdy); else n_pass++;
    n_total++; if (s_rv !== 1'b0) $display("FAIL badack_pulse_width: got %b want 0", s_rv); else n_pass++;
  endtask

  task automatic test_send_stall();
    logic [7:0] exp_b [5];
    logic [7:0] got;
    exp_b = '{8'h00, 8'h40, 8'h00, 8'hFE, 8'hCA};
    push_bad = 0;
    do_txn(1'b0, 4'h0, 32'hCAFE_0040, 32'h0, 32'h4433_2211, 4, 2, 5);
    n_total++; if (stall_cnt != 2) $display("FAIL stall_count_during: got %0d want 2", stall_cnt); else n_pass++;
    n_total++; if (push_bad != 0) $display("FAIL stall_push_while_full: got %0d want 0", push_bad); else n_pass++;
    n_total++; if (sent_q.size() != 5) $display("FAIL stall_count: got %0d want 5", sent_q.size()); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      n_total++; if (got !== exp_b[i]) $display("FAIL stall_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_total++; if (res_rdata !== 32'h4433_2211) $display("FAIL stall_rdata: got %h want 44332211", res_rdata); else n_pass++;
    n_total++; if (res_err !== 1'b0) $display("FAIL stall_err_cleared: got %b want 0", res_err); else n_pass++;
    tick();
  endtask

  task automatic test_timeout();
    do_txn(1'b0, 4'h0, 32'h0000_0020, 32'h0, 32'h0000_CDAB, 2, 0, 5);
    n_total++; if (res_done !== 1'b1) $display("FAIL tmo_done: got %b want 1", res_done); else n_pass++;
    n_total++; if (res_err !== 1'b1) $display("FAIL tmo_err: got %b want 1", res_err); else n_pass++;
    n_total++; if (res_rdata !== 32'h4433_CDAB) $display("FAIL tmo_rdata: got %h want 4433cdab", res_rdata); else n_pass++;
    n_total++; if (res_cyc - last_pop != 100) $display("FAIL tmo_latency: got %0d want 100", res_cyc - last_pop); else n_pass++;
    tick();
  endtask

  task automatic test_reset_mid_recv();
    logic acc;
    logic [7:0] exp_b [5];
    logic [7:0] got;
    exp_b = '{8'h00, 8'h44, 8'h00, 8'h00, 8'h00};
    sent_q.delete();
    acc = 1'b0;
    req_we = 1'b0; req_mask = 4'h0; req_addr = 32'h0000_0030; req_wdata = 32'h0;
    req_valid = 1'b1;
    for (int i = 0; i < 20 && !acc; i++) begin
      tick();
      if (s_rdy) acc = 1'b1;
    end
    req_valid = 1'b0;
    for (int i = 0; i < 100 && sent_q.size() < 5; i++) tick();
    recv_q.push_back(8'h99); recv_q.push_back(8'h88); update_if();
    repeat (10) tick();
    n_total++; if (s_rdata !== 32'h4433_8899) $display("FAIL rstmid_partial: got %h want 44338899", s_rdata); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (req_ready !== 1'b1) $display("FAIL rstmid_ready: got %b want 1", req_ready); else n_pass++;
    n_total++; if (resp_rdata !== 32'h0) $display("FAIL rstmid_rdata: got %h want 0", resp_rdata); else n_pass++;
    n_total++; if (resp_err !== 1'b0) $display("FAIL rstmid_err: got %b want 0", resp_err); else n_pass++;
    n_total++; if (resp_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", resp_valid); else n_pass++;
    n_total++; if (recv_flag !== 1'b0 || send_flag !== 1'b0) $display("FAIL rstmid_flags: got %b%b want 00", send_flag, recv_flag); else n_pass++;
    tick();
    n_total++; if (s_rv !== 1'b0) $display("FAIL rstmid_no_resp: got %b want 0", s_rv); else n_pass++;
    rst = 1'b0;
    recv_q.delete(); update_if();
    tick();
    do_txn(1'b0, 4'h0, 32'h0000_0044, 32'h0, 32'h0BAD_F00D, 4, 0, 5);
    for (int i = 0; i < 5; i++) begin
      got = (i < sent_q.size()) ? sent_q[i] : 8'hxx;
      n_total++; if (got !== exp_b[i]) $display("FAIL after_rst_byte%0d: got %h want %h", i, got, exp_b[i]); else n_pass++;
    end
    n_total++; if (res_done !== 1'b1) $display("FAIL after_rst_done: got %b want 1", res_done); else n_pass++;
    n_total++; if (res_rdata !== 32'h0BAD_F00D) $display("FAIL after_rst_rdata: got %h want 0badf00d", res_rdata); else n_pass++;
    n_total++; if (res_err !== 1'b0) $display("FAIL after_rst_err: got %b want 0", res_err); else n_pass++;
    n_total++; if (pop_bad != 0) $display("FAIL pop_while_empty: got %0d want 0", pop_bad); else n_pass++;
  endtask

  initial begin
    rst = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_mask = 4'h0; req_addr = 32'h0; req_wdata = 32'h0;
    hold = 1'b0; cyc = 0; last_pop = 0; push_bad = 0; pop_bad = 0; stall_cnt = 0;
    update_if();
    test_reset();
    test_load();
    test_store();
    test_store_bad_ack();
    test_send_stall();
    test_timeout();
    test_reset_mid_recv();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
